// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit for the EX stage.
// The unit multiplies by radix-2 shift-add and divides by restoring division,
// producing one bit per cycle. It uses a start/done handshake. flush abandons
// an operation in flight without producing a result.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
  localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] X_ZERO   = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] X_ONES   = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] X_MINNEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // Two's complement negation at operand width.
  function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v);
    return ~v + {{(XLEN-1){1'b0}}, 1'b1};
  endfunction

  // Two's complement negation at full product width.
  function automatic logic [2*XLEN-1:0] neg_2x(input logic [2*XLEN-1:0] v);
    return ~v + {{(2*XLEN-1){1'b0}}, 1'b1};
  endfunction

  state_t            state_q, state_d;
  logic [2:0]        f3_q, f3_d;
  logic              sa_q, sa_d;
  logic              sb_q, sb_d;
  logic              special_q, special_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;     // multiplicand (MUL) or divisor (DIV) magnitude
  logic [2*XLEN-1:0] prod_q, prod_d;     // {partial product high, remaining multiplier bits}
  logic [XLEN-1:0]   rem_q, rem_d;       // partial remainder
  logic [XLEN-1:0]   quo_q, quo_d;       // dividend bits shifting out, quotient bits in; special result
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              accept_s;
  logic              is_div_s;
  logic              sa_s;
  logic              sb_s;
  logic [XLEN-1:0]   a_mag_s;
  logic [XLEN-1:0]   b_mag_s;
  logic              div_zero_s;
  logic              div_ovf_s;
  logic [XLEN-1:0]   spec_val_s;
  logic [XLEN:0]     mul_sum_s;
  logic [XLEN:0]     div_shift_s;
  logic [XLEN:0]     div_diff_s;
  logic [2*XLEN-1:0] prod_fix_s;
  logic [XLEN-1:0]   quo_fix_s;
  logic [XLEN-1:0]   rem_fix_s;
  logic [XLEN-1:0]   fix_res_s;

  // Decode a new request: sign flags, operand magnitudes and divide special cases.
  always_comb begin
    accept_s = (state_q == S_IDLE) && start && !flush;
    is_div_s = funct3[2];
    sa_s = op_a[XLEN-1] && ((funct3 == 3'b001) || (funct3 == 3'b010) ||
                            (funct3 == 3'b100) || (funct3 == 3'b110));
    sb_s = op_b[XLEN-1] && ((funct3 == 3'b001) || (funct3 == 3'b100) ||
                            (funct3 == 3'b110));
    a_mag_s    = sa_s ? neg_x(op_a) : op_a;
    b_mag_s    = sb_s ? neg_x(op_b) : op_b;
    div_zero_s = is_div_s && (op_b == X_ZERO);
    // Only the signed forms (DIV, REM: funct3[0]=0) can overflow.
    div_ovf_s  = is_div_s && !funct3[0] && (op_a == X_MINNEG) && (op_b == X_ONES);
    if (div_zero_s) begin
      spec_val_s = funct3[1] ? op_a : X_ONES;
    end else begin
      spec_val_s = funct3[1] ? X_ZERO : op_a;
    end
  end

  // One iteration step of each datapath plus final sign fix-up and result select.
  always_comb begin
    mul_sum_s   = {1'b0, prod_q[2*XLEN-1:XLEN]} +
                  (prod_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
    // Guard bit: the shifted remainder can exceed XLEN bits before the subtract.
    div_shift_s = {rem_q, quo_q[XLEN-1]};
    div_diff_s  = div_shift_s - {1'b0, opnd_q};
    prod_fix_s  = (sa_q ^ sb_q) ? neg_2x(prod_q) : prod_q;
    quo_fix_s   = (sa_q ^ sb_q) ? neg_x(quo_q) : quo_q;
    rem_fix_s   = sa_q ? neg_x(rem_q) : rem_q;
    if (special_q) begin
      fix_res_s = quo_q;
    end else if (f3_q[2]) begin
      fix_res_s = f3_q[1] ? rem_fix_s : quo_fix_s;
    end else if (f3_q[1:0] == 2'b00) begin
      fix_res_s = prod_fix_s[XLEN-1:0];
    end else begin
      fix_res_s = prod_fix_s[2*XLEN-1:XLEN];
    end
  end

  // Next-state and datapath update for the sequencing FSM.
  always_comb begin
    state_d   = state_q;
    f3_d      = f3_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    special_d = special_q;
    cnt_d     = cnt_q;
    opnd_d    = opnd_q;
    prod_d    = prod_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    result_d  = result_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          f3_d  = funct3;
          sa_d  = sa_s;
          sb_d  = sb_s;
          cnt_d = {CW{1'b0}};
          if (div_zero_s || div_ovf_s) begin
            special_d = 1'b1;
            quo_d     = spec_val_s;
            state_d   = S_FIX;
          end else if (is_div_s) begin
            special_d = 1'b0;
            opnd_d    = b_mag_s;
            quo_d     = a_mag_s;
            rem_d     = X_ZERO;
            state_d   = S_DIV;
          end else begin
            special_d = 1'b0;
            opnd_d    = a_mag_s;
            prod_d    = {X_ZERO, b_mag_s};
            state_d   = S_MUL;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          prod_d  = {mul_sum_s, prod_q[XLEN-1:1]};
          cnt_d   = cnt_q + CNT_ONE;
          state_d = (cnt_q == CNT_LAST) ? S_FIX : S_MUL;
        end
      end
      S_DIV: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          if (!div_diff_s[XLEN]) begin
            rem_d = div_diff_s[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b1};
          end else begin
            rem_d = div_shift_s[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b0};
          end
          cnt_d   = cnt_q + CNT_ONE;
          state_d = (cnt_q == CNT_LAST) ? S_FIX : S_DIV;
        end
      end
      S_FIX: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          result_d = fix_res_s;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_MUL) || (state_d == S_DIV) || (state_d == S_FIX);
    done_d = (state_d == S_DONE);
  end

  // State and output registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      f3_q      <= 3'b000;
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      special_q <= 1'b0;
      cnt_q     <= {CW{1'b0}};
      opnd_q    <= X_ZERO;
      prod_q    <= {(2*XLEN){1'b0}};
      rem_q     <= X_ZERO;
      quo_q     <= X_ZERO;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= X_ZERO;
    end else begin
      state_q   <= state_d;
      f3_q      <= f3_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      special_q <= special_d;
      cnt_q     <= cnt_d;
      opnd_q    <= opnd_d;
      prod_q    <= prod_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
    end
  end

  assign ready  = (state_q == S_IDLE);
  assign busy   = busy_q;
  // A flush arriving in the DONE cycle still kills the pulse.
  assign done   = done_q && !flush;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit at XLEN=32 and XLEN=8.
// Expected results are queued when a request is driven and compared when done pulses.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start, flush;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b, result;
  logic        ready, busy, done;

  logic        s8_start, s8_flush;
  logic [2:0]  s8_funct3;
  logic [7:0]  s8_op_a, s8_op_b, s8_result;
  logic        s8_ready, s8_busy, s8_done;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int done_cnt8 = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  exp8_q[$];

  muldiv_unit #(.XLEN(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3), .op_a(op_a), .op_b(op_b),
    .flush(flush), .ready(ready), .busy(busy), .done(done), .result(result)
  );

  muldiv_unit #(.XLEN(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(s8_start), .funct3(s8_funct3), .op_a(s8_op_a),
    .op_b(s8_op_b), .flush(s8_flush), .ready(s8_ready), .busy(s8_busy), .done(s8_done),
    .result(s8_result)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  // Reference arithmetic at width w, computed with 64-bit integers.
  function automatic logic [31:0] ref_op(input int w, input logic [2:0] f3,
                                         input logic [31:0] a, input logic [31:0] b);
    logic [63:0] mask;
    longint as_v, bs_v, ps, minneg;
    longint unsigned ua, ub, pu;
    logic [63:0] r;
    mask = (64'd1 << w) - 64'd1;
    ua = {32'd0, a} & mask;
    ub = {32'd0, b} & mask;
    as_v = longint'(ua);
    bs_v = longint'(ub);
    if (ua[w-1]) as_v = as_v - (longint'(1) << w);
    if (ub[w-1]) bs_v = bs_v - (longint'(1) << w);
    minneg = -(longint'(1) << (w - 1));
    case (f3)
      3'd0: begin ps = as_v * bs_v; r = ps; end
      3'd1: begin ps = as_v * bs_v; r = ps >>> w; end
      3'd2: begin ps = as_v * longint'(ub); r = ps >>> w; end
      3'd3: begin pu = ua * ub; r = pu >> w; end
      3'd4: begin
        if (ub == 0) r = mask;
        else if (as_v == minneg && bs_v == -1) r = ua;
        else r = as_v / bs_v;
      end
      3'd5: r = (ub == 0) ? mask : ua / ub;
      3'd6: begin
        if (ub == 0) r = ua;
        else if (as_v == minneg && bs_v == -1) r = 64'd0;
        else r = as_v % bs_v;
      end
      3'd7: r = (ub == 0) ? ua : ua % ub;
      default: r = 64'd0;
    endcase
    r = r & mask;
    return r[31:0];
  endfunction

  // Scoreboard for the 32-bit unit.
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      check_eq("done_expected32", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (exp_q.size() > 0) check_eq("result32", result, exp_q.pop_front());
    end
  end

  // Scoreboard for the 8-bit unit.
  always @(negedge clk) begin
    if (rst_n && s8_done) begin
      done_cnt8++;
      check_eq("done_expected8", (exp8_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (exp8_q.size() > 0) check_eq("result8", 32'(s8_result), 32'(exp8_q.pop_front()));
    end
  end

  task automatic op32(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp, input int lat, input bit poke);
    int n;
    int busy_n;
    logic ready_seen;
    n = 1;
    busy_n = 0;
    ready_seen = 1'b0;
    exp_q.push_back(exp);
    funct3 = f3; op_a = a; op_b = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    funct3 = 3'($urandom); op_a = $urandom; op_b = $urandom;
    while (!done && n < 100) begin
      busy_n += int'(busy);
      ready_seen = ready_seen | ready;
      start = poke && (n == 4);
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    check_eq("latency32", n, lat);
    check_eq("busy_cycles32", busy_n, lat - 1);
    check_eq("ready_low32", 32'(ready_seen), 32'd0);
    check_eq("ready_in_done32", 32'(ready), 32'd0);
    @(posedge clk); #1;
    check_eq("ready_after32", 32'(ready), 32'd1);
  endtask

  task automatic op8(input logic [2:0] f3, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] exp, input int lat);
    int n;
    n = 1;
    exp8_q.push_back(exp);
    s8_funct3 = f3; s8_op_a = a; s8_op_b = b; s8_start = 1'b1;
    @(posedge clk); #1;
    s8_start = 1'b0;
    s8_op_a = 8'($urandom); s8_op_b = 8'($urandom);
    while (!s8_done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("latency8", n, lat);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a, b;
    logic [7:0]  a8, b8;
    int          base;
    bit          spec;
    start = 1'b0; flush = 1'b0; funct3 = 3'd0; op_a = 32'd0; op_b = 32'd0;
    s8_start = 1'b0; s8_flush = 1'b0; s8_funct3 = 3'd0; s8_op_a = 8'd0; s8_op_b = 8'd0;
    #3;
    check_eq("rst_ready", 32'(ready), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_result", result, 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    op32(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 1'b0);
    op32(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 1'b0);
    op32(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 1'b0);
    op32(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 1'b0);
    op32(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 1'b0);
    op32(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 1'b0);
    op32(3'd5, 32'd100, 32'd7, 32'd14, 34, 1'b1);   // start pulses while busy
    op32(3'd7, 32'd100, 32'd7, 32'd2, 34, 1'b0);

    // Flush 10 cycles into a DIV, then start+flush together: neither may complete.
    base = done_cnt;
    funct3 = 3'd4; op_a = 32'd1000; op_b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check_eq("flush_ready", 32'(ready), 32'd1);
    check_eq("flush_busy", 32'(busy), 32'd0);
    start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check_eq("startflush_ready", 32'(ready), 32'd1);
    check_eq("startflush_busy", 32'(busy), 32'd0);
    repeat (40) @(posedge clk);
    #1;
    check_eq("flush_no_done", done_cnt, base);
    check_eq("flush_result_held", result, 32'd2);

    op32(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 2, 1'b0);
    op32(3'd6, 32'd5, 32'd0, 32'd5, 2, 1'b0);
    op32(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, 1'b0);
    op32(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2, 1'b0);

    // Reset in the middle of a MUL.
    base = done_cnt;
    funct3 = 3'd0; op_a = 32'd3; op_b = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #2;
    check_eq("midrst_ready", 32'(ready), 32'd1);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_done", 32'(done), 32'd0);
    check_eq("midrst_result", result, 32'd0);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check_eq("midrst_no_done", done_cnt, base);
    op32(3'd0, 32'd3, 32'd4, 32'd12, 34, 1'b0);

    // Randomised sweep against the reference model at XLEN=32.
    for (int i = 0; i < 16; i++) begin
      f3 = 3'(i % 8);
      a = (i == 9) ? 32'h8000_0000 : $urandom;
      b = (i == 12) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
      spec = f3[2] && ((b == 32'd0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
      op32(f3, a, b, ref_op(32, f3, a, b), spec ? 2 : 34, 1'b0);
    end

    // XLEN=8 sweep, including the divide corner cases.
    op8(3'd3, 8'hFF, 8'hFF, 8'hFE, 10);
    for (int g = 0; g < 8; g++) begin
      for (int k = 0; k < 4; k++) begin
        f3 = 3'(g);
        a8 = (k == 0) ? 8'h80 : 8'($urandom);
        b8 = (k == 1) ? 8'h00 : ((k == 2) ? 8'hFF : 8'($urandom));
        spec = f3[2] && ((b8 == 8'h00) || (!f3[0] && a8 == 8'h80 && b8 == 8'hFF));
        a = {24'd0, a8};
        b = {24'd0, b8};
        a = ref_op(8, f3, a, b);
        op8(f3, a8, b8, a[7:0], spec ? 2 : 10);
      end
    end

    check_eq("queue_drained32", exp_q.size(), 32'd0);
    check_eq("queue_drained8", exp8_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Parametrised iterative multiply/divide unit implementing the RV32M operation set (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) for the EX stage. It sits beside the single-cycle ALU and uses a start/done handshake. The pipeline holds EX and stalls upstream stages while busy is high. Flush kills an in-flight operation without producing a result.

Parameters:
XLEN, 32, operand/result width (≥4); iteration counter width is clog2(XLEN)+1

Ports:
clk  input  1  system clock, all state rising-edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; accepted only when ready=1 and flush=0
funct3  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
op_a  input  XLEN  rs1 value (multiplicand / dividend)
op_b  input  XLEN  rs2 value (multiplier / divisor)
flush  input  1  abort current op (branch mispredict / trap)
ready  output  1  high in IDLE only
busy  output  1  high from the cycle after accept until done is asserted
done  output  1  one-cycle pulse: result valid
result  output  XLEN  result; held from done until next accepted start

Behaviour:
- Reset (async, rst_n=0): state=IDLE, ready=1, busy=0, done=0, result=0, counter=0. Reset mid-operation discards all state; no done follows.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE: on start&!flush latch funct3; compute sign flags: sa = op_a[XLEN-1] for MULH/MULHSU/DIV/REM; sb = op_b[XLEN-1] for MULH/DIV/REM; load operand magnitudes; counter=0.
  - Divide with op_b==0, or signed overflow (DIV/REM, op_a=100..0, op_b=all ones): go straight to FIX with the special result preloaded.
  - Otherwise go to MUL (funct3[2]=0) or DIV (funct3[2]=1).
- MUL: radix-2 shift-add, one multiplier bit per cycle into a 2*XLEN accumulator. After exactly XLEN cycles go to FIX.
- DIV: restoring division, one quotient bit per cycle, XLEN-bit remainder plus one guard bit. After exactly XLEN cycles go to FIX.
- FIX:
  - Multiply: product negated (2*XLEN two's complement) if sa^sb. MUL selects the low half; MULH/MULHSU/MULHU select the high half.
  - Divide: quotient negated if sa^sb; remainder negated if sa (remainder takes the dividend's sign).
  - Special cases:
    - x/0: quotient all ones (DIV and DIVU); remainder = op_a.
    - Signed overflow: quotient = op_a; remainder = 0.
  - Register result; go to DONE.
- DONE: done=1 for this single cycle; go to IDLE. ready=0 here, so back-to-back start is accepted the cycle after done.
- Latency from accept edge to done high:
  - Normal ops: XLEN+2 cycles (34 at XLEN=32).
  - Special divide cases: 2 cycles.
- Ignored starts: start while ready=0 is ignored (no queueing). start and flush in the same cycle: flush wins, nothing accepted.
- flush in MUL/DIV/FIX/DONE: next state IDLE, done suppressed (flush during DONE forces done=0 that cycle), result unchanged. ready=1 the following cycle.
- Outputs are registered (busy, done, result) or state-decoded (ready). No combinational path from op_a/op_b to outputs.
- Sign-related operands are read only at accept; later changes to op_a/op_b/funct3 have no effect.

Test Plan:
- MUL op_a=7, op_b=0xFFFFFFFD (-3) -> result=0xFFFFFFEB, done exactly 34 cycles after accept; busy high 33 cycles; ready low throughout.
- High multiplies -> MULH 0x80000000*0x80000000 = 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF = 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF = 0xFFFFFFFF.
- Signed divide -> DIV 0xFFFFFFF9/2 = 0xFFFFFFFD; REM 0xFFFFFFF9/2 = 0xFFFFFFFF; DIVU 100/7 = 14; REMU 100/7 = 2.
- Special cases, done 2 cycles after accept -> DIVU 5/0 = 0xFFFFFFFF; REM 5/0 = 5; DIV 0x80000000/0xFFFFFFFF = 0x80000000; REM same operands = 0.
- Abort and ignored starts:
  - flush 10 cycles into a DIV -> no done ever; ready=1 next cycle.
  - start+flush same cycle -> not accepted.
  - start pulses while busy -> ignored; first result unaffected.
- rst_n low mid-MUL, then released -> ready=1, done=0, result=0. Fresh MUL 3*4 -> 12. Repeat full op sweep with XLEN=8 (e.g. MULHU 0xFF*0xFF = 0xFE, done at 10 cycles).
